// File: rtl/fractal_job_scheduler.sv
// rtl/fractal_job_scheduler.sv - round-robin fractal job dispatcher with raster-order result collection
module fractal_job_scheduler #(
    parameter int N_ENGINES = 4,
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int PTR_W     = $clog2(N_ENGINES)
) (
    input  logic                   out_stream_aclk,
    input  logic                   periph_resetn,
    input  logic                   enable,
    input  logic [7:0]             cfg_max_iter,
    output logic [N_ENGINES-1:0]   job_valid,
    input  logic [N_ENGINES-1:0]   job_ready,
    output logic [9:0]             job_x,
    output logic [8:0]             job_y,
    output logic [7:0]             job_max_iter,
    input  logic [N_ENGINES-1:0]   res_valid,
    input  logic [8*N_ENGINES-1:0] res_iter,
    output logic [N_ENGINES-1:0]   res_ready,
    output logic                   pix_valid,
    output logic [7:0]             pix_iter,
    output logic                   pix_sof,
    output logic                   pix_eol,
    input  logic                   pix_ready,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int                   CNT_W    = $clog2(N_ENGINES + 1);
    localparam logic [9:0]           X_LAST   = 10'(X_SIZE - 1);
    localparam logic [8:0]           Y_LAST   = 9'(Y_SIZE - 1);
    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(N_ENGINES - 1);
    localparam logic [N_ENGINES-1:0] ONE_HOT0 = N_ENGINES'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PTR_W-1:0]     r_d_ptr;
    logic [PTR_W-1:0]     r_r_ptr;
    logic [9:0]           r_dx;
    logic [8:0]           r_dy;
    logic [9:0]           r_ox;
    logic [8:0]           r_oy;
    logic [CNT_W-1:0]     r_inflight;
    logic [N_ENGINES-1:0] r_job_valid;
    logic [7:0]           r_job_max_iter;
    logic                 r_pix_valid;
    logic [7:0]           r_pix_iter;
    logic                 r_pix_sof;
    logic                 r_pix_eol;
    logic                 r_pix_last;
    logic                 r_frame_done;

    logic                 w_start;
    logic                 w_dispatch;
    logic                 w_d_last;
    logic [PTR_W-1:0]     w_d_ptr_next;
    logic [PTR_W-1:0]     w_r_ptr_next;
    logic                 w_out_free;
    logic [N_ENGINES-1:0] w_res_ready;
    logic                 w_collect;
    logic [7:0]           w_res_sel;

    assign w_start      = (r_state == S_IDLE) && enable;
    assign w_dispatch   = |(r_job_valid & job_ready);
    assign w_d_last     = (r_dx == X_LAST) && (r_dy == Y_LAST);
    assign w_d_ptr_next = (r_d_ptr == PTR_LAST) ? '0 : r_d_ptr + PTR_W'(1);
    assign w_r_ptr_next = (r_r_ptr == PTR_LAST) ? '0 : r_r_ptr + PTR_W'(1);
    // Only the engine owning the next raster pixel may hand over a result.
    assign w_out_free   = !r_pix_valid || pix_ready;
    assign w_res_ready  = ((r_inflight != '0) && w_out_free) ? (ONE_HOT0 << r_r_ptr) : '0;
    assign w_collect    = res_valid[r_r_ptr] && w_res_ready[r_r_ptr];
    assign w_res_sel    = res_iter[{r_r_ptr, 3'b000} +: 8];

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_state_next = S_RUN;
            S_RUN:   if (w_dispatch && w_d_last && !enable) w_state_next = S_DRAIN;
            S_DRAIN: if ((r_inflight == '0) && !r_pix_valid) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_d_ptr        <= '0;
            r_dx           <= '0;
            r_dy           <= '0;
            r_job_valid    <= '0;
            r_job_max_iter <= '0;
        end else if (w_start) begin
            r_d_ptr        <= '0;
            r_dx           <= '0;
            r_dy           <= '0;
            r_job_valid    <= ONE_HOT0;
            r_job_max_iter <= cfg_max_iter;
        end else if ((r_state == S_RUN) && w_dispatch) begin
            r_d_ptr <= w_d_ptr_next;
            if (r_dx == X_LAST) begin
                r_dx <= '0;
                r_dy <= (r_dy == Y_LAST) ? '0 : r_dy + 9'd1;
            end else begin
                r_dx <= r_dx + 10'd1;
            end
            // Frame wrap: either stop offering or re-latch the limit for the next frame.
            if (w_d_last && !enable) begin
                r_job_valid <= '0;
            end else begin
                r_job_valid <= ONE_HOT0 << w_d_ptr_next;
            end
            if (w_d_last && enable) begin
                r_job_max_iter <= cfg_max_iter;
            end
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_inflight <= '0;
        end else if (w_dispatch && !w_collect) begin
            r_inflight <= r_inflight + CNT_W'(1);
        end else if (!w_dispatch && w_collect) begin
            r_inflight <= r_inflight - CNT_W'(1);
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_r_ptr <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else if (w_start) begin
            r_r_ptr <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else if (w_collect) begin
            r_r_ptr <= w_r_ptr_next;
            if (r_ox == X_LAST) begin
                r_ox <= '0;
                r_oy <= (r_oy == Y_LAST) ? '0 : r_oy + 9'd1;
            end else begin
                r_ox <= r_ox + 10'd1;
            end
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_pix_valid  <= 1'b0;
            r_pix_iter   <= '0;
            r_pix_sof    <= 1'b0;
            r_pix_eol    <= 1'b0;
            r_pix_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_collect) begin
                r_pix_valid <= 1'b1;
                r_pix_iter  <= w_res_sel;
                r_pix_sof   <= (r_ox == '0) && (r_oy == '0);
                r_pix_eol   <= (r_ox == X_LAST);
                r_pix_last  <= (r_ox == X_LAST) && (r_oy == Y_LAST);
            end else if (pix_ready) begin
                r_pix_valid <= 1'b0;
            end
            r_frame_done <= r_pix_valid && pix_ready && r_pix_last;
        end
    end

    assign job_valid    = r_job_valid;
    assign job_x        = r_dx;
    assign job_y        = r_dy;
    assign job_max_iter = r_job_max_iter;
    assign res_ready    = w_res_ready;
    assign pix_valid    = r_pix_valid;
    assign pix_iter     = r_pix_iter;
    assign pix_sof      = r_pix_sof;
    assign pix_eol      = r_pix_eol;
    assign busy         = (r_state != S_IDLE);
    assign frame_done   = r_frame_done;

endmodule

// File: doc/fractal_job_scheduler.md
# fractal_job_scheduler

Dispatches pixel jobs (x, y, max_iter) round-robin to `N_ENGINES` fractal iteration engines. Collects their iteration counts and presents them strictly in raster order to the colour/packer stage. It replaces the fixed even/odd engine pairing in the pixel generator with a scalable, back-pressure-aware scheduler. It also latches `cfg_max_iter` only at frame boundaries, so a register-file write never tears a frame.

## Interface
- `N_ENGINES`, 4: number of engines (2..8); `PTR_W = $clog2(N_ENGINES)`
- `X_SIZE`, 640: pixels per line
- `Y_SIZE`, 480: lines per frame
- `out_stream_aclk` in 1: the single clock
- `periph_resetn` in 1: reset, asynchronous, active-low
- `enable` in 1: run request, level
- `cfg_max_iter` in 8: iteration limit from the register file
- `job_valid` out N_ENGINES: one-hot offer to engine i
- `job_ready` in N_ENGINES: engine i idle and able to accept a job
- `job_x` out 10: shared job coordinate
- `job_y` out 9: shared job coordinate
- `job_max_iter` out 8: frame-latched limit
- `res_valid` in N_ENGINES: engine i has a result
- `res_iter` in 8*N_ENGINES: result of engine i in bits [8i+7:8i]
- `res_ready` out N_ENGINES: one-hot result accept
- `pix_valid` out 1: to packer
- `pix_iter` out 8: to packer
- `pix_sof` out 1: to packer
- `pix_eol` out 1: to packer
- `pix_ready` in 1: from packer
- `busy` out 1: state != IDLE
- `frame_done` out 1: one-cycle pulse

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN when `enable`=1. On this transition: `job_max_iter` ← `cfg_max_iter`, dispatch pointer `d_ptr`=0, dispatch coordinates `dx`/`dy`=0.
  - RUN → DRAIN when the last pixel (X_SIZE-1, Y_SIZE-1) is dispatched and `enable`=0.
  - If `enable` stays 1 at that point, remain in RUN: wrap `dx`/`dy` to 0 and re-latch `job_max_iter` from `cfg_max_iter` in the same cycle.
  - DRAIN → IDLE when `inflight`=0 and `pix_valid`=0.
  - `enable` falling mid-frame does not stop dispatch; the current frame always completes.
- Dispatch (RUN only):
  - `job_valid[d_ptr]`=1 and all other bits 0. `job_x`=`dx`, `job_y`=`dy`.
  - Hold the offer until `job_ready[d_ptr]`.
  - On the handshake: advance `dx`; at X_SIZE-1, wrap to 0 and advance `dy`; at Y_SIZE-1, wrap `dy`. `d_ptr` ← (`d_ptr`+1) mod N_ENGINES. `inflight` increments.
  - No dispatch in IDLE or DRAIN.
- Each engine holds at most one job. Round-robin dispatch plus round-robin collection therefore guarantees raster order without a reorder buffer.
- Collection:
  - `res_ready[r_ptr]` = (`inflight`≠0) && (!`pix_valid` || `pix_ready`). All other bits are 0.
  - Results from engines other than `r_ptr` wait, even if valid earlier.
  - On `res_valid[r_ptr]` && `res_ready[r_ptr]`: load the output register, `r_ptr`++ mod N_ENGINES, `inflight` decrements.
- Output register:
  - `pix_iter` = captured result.
  - `pix_sof` = (`ox`==0 && `oy`==0) and `pix_eol` = (`ox`==X_SIZE-1), computed from output-side coordinates `ox`/`oy` at capture.
  - `ox`/`oy` advance and wrap like `dx`/`dy` on each capture.
  - `pix_valid` is held with stable data until `pix_ready`.
- `inflight` range is 0..N_ENGINES. A simultaneous dispatch and collect leaves it unchanged.
- `frame_done` pulses in the cycle after the pixel with `ox`=X_SIZE-1, `oy`=Y_SIZE-1 is accepted by the packer.
- Reset (asynchronous) values: state=IDLE; all pointers, counters, `inflight` = 0; `job_valid`=0; `pix_valid`=0; `pix_iter`/`pix_sof`/`pix_eol` = 0; `frame_done`=0; `job_max_iter`=0. `res_ready`=0 follows from `inflight`=0.
- Reset mid-frame drops in-flight work. Engines are reset by the same `periph_resetn`.

## Timing
- `job_valid` and `job_x`/`job_y` are registered. A dispatch can occur every cycle if engines are ready.
- Back-to-back offers to successive engines need no idle cycle.
- Result handshake at edge k → `pix_valid`=1 after edge k.
- `res_ready` is combinational from `pix_ready`. With `pix_ready`=1 the path sustains 1 pixel/cycle.
- `cfg_max_iter` is sampled only on the IDLE→RUN transition and at the frame wrap in RUN. Changes mid-frame take effect from the next frame.
- Assertion on `pix_valid`: `pix_valid` && !`pix_ready` ⇒ `pix_valid`, `pix_iter`, `pix_sof`, `pix_eol` unchanged next cycle.

## Test plan
- N=4, engines respond in 3 cycles with `iter`=x[7:0], `pix_ready`=1 → pixels emerge with `pix_iter` 0,1,2,…; `pix_sof` only on the first pixel; `pix_eol` on `ox`=639; `frame_done` one pulse after the 307200th pixel.
- Engine 1 finishes 20 cycles before engine 0 → `res_ready[1]` stays 0 until engine 0 is collected; output order is x=0 then x=1.
- `pix_ready` held low for 50 cycles → `pix_valid` and data are stable; `inflight` saturates at 4 and `job_valid` stalls; no pixel is lost or duplicated after release.
- `enable` drops at pixel (100,10) → dispatch continues to (639,479), then DRAIN, then IDLE with `busy`=0; total output count is 307200.
- `cfg_max_iter` changes 80→50 mid-frame → `job_max_iter`=80 until the wrap, 50 for the first job of the next frame.
- `periph_resetn` asserted mid-frame, asynchronously → all outputs reach reset values before the next edge; after release with `enable`=1, the first job is (0,0) to engine 0.
